// File: rtl/signed_bcd_converter_pkg.sv
// ============================================================================
// Module   : signed_bcd_converter_pkg
// Brief    : Shared types and constants for the signed BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package signed_bcd_converter_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Width of a counter that must hold the value w itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/signed_bcd_converter_if.sv
// ============================================================================
// Module   : signed_bcd_converter_if
// Brief    : Start/done handshake and result bus of the signed BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signed_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  ovf_in;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, value, ovf_in,
    input  busy, done, sign, ovf, bcd
  );

  modport slave (
    input  start, value, ovf_in,
    output busy, done, sign, ovf, bcd
  );

endinterface

`default_nettype wire

// File: rtl/signed_bcd_converter_digit_adjust.sv
// ============================================================================
// Module   : bcd_digit_adjust
// Brief    : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
  input  wire logic [3:0] digit_i,
  output logic      [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

`default_nettype wire

// File: rtl/signed_bcd_converter.sv
// ============================================================================
// Module   : signed_bcd_converter
// Brief    : Iterative two's-complement to sign + BCD converter, one
//            double-dabble shift per clock with a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_bcd_converter
  import signed_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input wire logic                 CLK,
  input wire logic                 RST,
  signed_bcd_converter_if.slave    bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_e              state_q;
  logic [CW-1:0]       count_q;
  logic [WIDTH-1:0]    mag_q;
  logic [BW-1:0]       scratch_q;
  logic                sign_int_q;
  logic                ovf_int_q;

  logic [BW-1:0]       bcd_q;
  logic                sign_q;
  logic                ovf_q;
  logic                done_q;

  logic [BW-1:0]       scratch_adj;
  logic [BW-1:0]       scratch_d;
  logic [WIDTH-1:0]    mag_d;
  logic [WIDTH-1:0]    mag_load;

  // -128 negates to 0x80, which read as unsigned is the correct magnitude.
  assign mag_load = bus.value[WIDTH-1] ? ((~bus.value) + WIDTH'(1)) : bus.value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  assign scratch_d = {scratch_adj[BW-2:0], mag_q[WIDTH-1]};
  assign mag_d     = {mag_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mag_q      <= '0;
      scratch_q  <= '0;
      sign_int_q <= 1'b0;
      ovf_int_q  <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_int_q <= bus.value[WIDTH-1];
            mag_q      <= mag_load;
            ovf_int_q  <= bus.ovf_in;
            scratch_q  <= '0;
            count_q    <= CW'(WIDTH);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          count_q   <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          bcd_q   <= scratch_q;
          sign_q  <= sign_int_q;
          ovf_q   <= ovf_int_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.sign = sign_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd  = bcd_q;

endmodule

`default_nettype wire
